// File: rtl/pic_bus_master.sv
// rtl/pic_bus_master.sv - 8259-style PIC bus master with timed CS/RD/WR strobes
// Runs single host accesses and the ICW1..ICW4 init write sequence.
module pic_bus_master #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int RECOVERY_CYC = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       A0,
  output logic [7:0] Data_out,
  output logic       Data_oe,
  input  logic [7:0] Data_in,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       op_done,
  output logic       init_busy,
  output logic       init_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_rw;
  logic [3:0][7:0] r_seq;
  logic [2:0]      r_seq_cnt;
  logic [2:0]      r_seq_idx;

  logic            w_init_go;
  logic            w_start;
  logic            w_rw;
  logic            w_a0;
  logic [7:0]      w_data;
  logic [3:0][7:0] w_seq;
  logic [2:0]      w_seq_cnt;

  assign w_init_go = (r_state == S_IDLE) && !init_busy && init_start;
  assign cmd_ready = (r_state == S_IDLE) && !init_busy && !init_start;

  // ICW3 only exists in cascade mode (icw1[1]=0), ICW4 only when icw1[0] requests it.
  always_comb begin
    w_seq[0]  = icw1 | 8'h10;
    w_seq[1]  = icw2;
    w_seq[2]  = 8'h00;
    w_seq[3]  = 8'h00;
    w_seq_cnt = 3'd2;
    case (icw1[1:0])
      2'b00: begin w_seq[2] = icw3; w_seq_cnt = 3'd3; end
      2'b01: begin w_seq[2] = icw3; w_seq[3] = icw4; w_seq_cnt = 3'd4; end
      2'b11: begin w_seq[2] = icw4; w_seq_cnt = 3'd3; end
      default: w_seq_cnt = 3'd2;
    endcase
  end

  // Next init word chains straight out of the last RECOVER cycle, skipping IDLE.
  always_comb begin
    w_start = 1'b0;
    w_rw    = cmd_rw;
    w_a0    = cmd_a0;
    w_data  = cmd_data;
    if (w_init_go) begin
      w_start = 1'b1;
      w_rw    = 1'b0;
      w_a0    = 1'b0;
      w_data  = w_seq[0];
    end else if (cmd_valid && cmd_ready) begin
      w_start = 1'b1;
    end else if (r_state == S_RECOVER && r_cnt == 4'd0 && init_busy) begin
      w_start = 1'b1;
      w_rw    = 1'b0;
      w_a0    = 1'b1;
      w_data  = r_seq[r_seq_idx[1:0]];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_rw      <= 1'b0;
      r_seq     <= '0;
      r_seq_cnt <= 3'd0;
      r_seq_idx <= 3'd0;
      CS        <= 1'b1;
      RD        <= 1'b1;
      WR        <= 1'b1;
      A0        <= 1'b0;
      Data_out  <= 8'h00;
      Data_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      op_done   <= 1'b0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
    end else begin
      op_done   <= 1'b0;
      rsp_valid <= 1'b0;
      init_done <= 1'b0;
      if (w_start) begin
        r_state  <= S_SETUP;
        r_cnt    <= 4'(SETUP_CYC - 1);
        r_rw     <= w_rw;
        CS       <= 1'b0;
        A0       <= w_a0;
        RD       <= 1'b1;
        WR       <= 1'b1;
        Data_oe  <= !w_rw;
        Data_out <= w_rw ? 8'h00 : w_data;
        if (w_init_go) begin
          r_seq     <= w_seq;
          r_seq_cnt <= w_seq_cnt;
          r_seq_idx <= 3'd0;
          init_busy <= 1'b1;
        end
      end else begin
        case (r_state)
          S_SETUP: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_STROBE;
              r_cnt   <= 4'(STROBE_CYC - 1);
              RD      <= !r_rw;
              WR      <= r_rw;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_STROBE: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_HOLD;
              RD      <= 1'b1;
              WR      <= 1'b1;
              op_done <= 1'b1;
              if (r_rw) begin
                rsp_valid <= 1'b1;
                rsp_data  <= Data_in;
              end
              if (init_busy) begin
                r_seq_idx <= r_seq_idx + 3'd1;
                if (r_seq_idx == r_seq_cnt - 3'd1) init_done <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_HOLD: begin
            r_state  <= S_RECOVER;
            r_cnt    <= 4'(RECOVERY_CYC - 1);
            CS       <= 1'b1;
            Data_oe  <= 1'b0;
            Data_out <= 8'h00;
            if (init_busy && r_seq_idx == r_seq_cnt) init_busy <= 1'b0;
          end
          S_RECOVER: begin
            if (r_cnt == 4'd0) r_state <= S_IDLE;
            else               r_cnt   <= r_cnt - 4'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
